// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path.
package uart_rx_pkg;

    localparam int unsigned UART_FIFO_DEPTH  = 32;
    localparam int unsigned UART_SYNC_STAGES = 2;
    localparam int unsigned UART_DATA_W      = 8;

    // Dividers below this leave no room for a mid-bit sample point.
    localparam logic [15:0] UART_MIN_BAUD_DIV = 16'd4;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } uart_rx_state_t;

    function automatic logic baud_div_ok(input logic [15:0] div);
        return div >= UART_MIN_BAUD_DIV;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// First-word-fall-through byte FIFO; the head entry is always visible on dout_o.
module uart_fifo
    import uart_rx_pkg::*;
#(
    parameter int unsigned DEPTH = UART_FIFO_DEPTH
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  logic [UART_DATA_W-1:0] din_i,
    input  logic                   pop_i,
    output logic [UART_DATA_W-1:0] dout_o,
    output logic                   full_o,
    output logic                   empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    // Extra MSB distinguishes full from empty when the low bits match.
    logic [AW:0]            wr_ptr_q, wr_ptr_d;
    logic [AW:0]            rd_ptr_q, rd_ptr_d;
    logic [UART_DATA_W-1:0] mem_q [DEPTH];
    logic                   do_push, do_pop;

    // Status flags and qualified strobes.
    always_comb begin
        full_o   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        empty_o  = (wr_ptr_q == rd_ptr_q);
        do_push  = push_i && !full_o;
        do_pop   = pop_i && !empty_o;
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        dout_o   = mem_q[rd_ptr_q[AW-1:0]];
    end

    // Pointer registers; they wrap naturally at 2*DEPTH.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is left unreset; only entries between the pointers are meaningful.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din_i;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver with mid-bit sampling, feeding a FWFT byte FIFO.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int unsigned DEPTH       = UART_FIFO_DEPTH,
    parameter int unsigned SYNC_STAGES = UART_SYNC_STAGES
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [15:0]            baud_div_i,
    input  logic                   rx_en_i,
    input  logic                   rx_re_i,
    input  logic                   rx_bit_i,
    output logic [UART_DATA_W-1:0] dout_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic                   frame_err_o,
    output logic                   overrun_o
);

    uart_rx_state_t         state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    logic [15:0]            baud_cnt_q, baud_cnt_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [UART_DATA_W-1:0] sh_q, sh_d;
    logic                   frame_err_q, frame_err_d;
    logic                   overrun_q, overrun_d;
    logic                   push;
    logic [15:0]            half_m1;
    logic [15:0]            full_m1;

    assign rx_s    = sync_q[SYNC_STAGES-1];
    assign half_m1 = (baud_div_i >> 1) - 16'd1;
    assign full_m1 = baud_div_i - 16'd1;

    // Line synchronizer; resets to the idle-high level so reset never looks like a start bit.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_bit_i};
        end
    end

    // Frame FSM next-state, bit timing and push/flag decisions.
    always_comb begin
        state_d     = state_q;
        baud_cnt_d  = baud_cnt_q + 16'd1;
        bit_cnt_d   = bit_cnt_q;
        sh_d        = sh_q;
        push        = 1'b0;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;

        if (!rx_en_i || !baud_div_ok(baud_div_i)) begin
            state_d    = RX_IDLE;
            baud_cnt_d = '0;
        end else begin
            unique case (state_q)
                RX_IDLE: begin
                    baud_cnt_d = '0;
                    if (!rx_s) begin
                        state_d = RX_START;
                    end
                end
                RX_START: begin
                    // Re-check the start bit at its midpoint to reject short glitches.
                    if (baud_cnt_q == half_m1) begin
                        baud_cnt_d = '0;
                        if (!rx_s) begin
                            state_d   = RX_DATA;
                            bit_cnt_d = '0;
                        end else begin
                            state_d = RX_IDLE;
                        end
                    end
                end
                RX_DATA: begin
                    if (baud_cnt_q == full_m1) begin
                        baud_cnt_d = '0;
                        sh_d       = {rx_s, sh_q[UART_DATA_W-1:1]};
                        if (bit_cnt_q == 3'd7) begin
                            state_d = RX_STOP;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end
                RX_STOP: begin
                    if (baud_cnt_q == full_m1) begin
                        baud_cnt_d = '0;
                        state_d    = RX_IDLE;
                        if (!rx_s) begin
                            frame_err_d = 1'b1;
                        end else if (full_o) begin
                            overrun_d = 1'b1;
                        end else begin
                            push = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // FSM, counters, shift register and registered error pulses.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= RX_IDLE;
            baud_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            sh_q        <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            baud_cnt_q  <= baud_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            sh_q        <= sh_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign frame_err_o = frame_err_q;
    assign overrun_o   = overrun_q;

    uart_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push_i (push),
        .din_i  (sh_q),
        .pop_i  (rx_re_i),
        .dout_o (dout_o),
        .full_o (full_o),
        .empty_o(empty_o)
    );

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: drives 8N1 frames at 16 clk/bit and checks FIFO and flags.
module tb_uart_rx;

    localparam int BAUD = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] baud_div = 16'(BAUD);
    logic        rx_en = 1'b1;
    logic        rx_re = 1'b0;
    logic        rx_line = 1'b1;
    logic [7:0]  dout;
    logic        full, empty, frame_err, overrun;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;
    int fe_hi  = 0;
    int ov_hi  = 0;
    int last_fall_cyc = 0;
    logic empty_prev = 1'b1;

    uart_rx u_dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .baud_div_i (baud_div),
        .rx_en_i    (rx_en),
        .rx_re_i    (rx_re),
        .rx_bit_i   (rx_line),
        .dout_o     (dout),
        .full_o     (full),
        .empty_o    (empty),
        .frame_err_o(frame_err),
        .overrun_o  (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Flag-high cycle counts and the cycle of the latest empty_o falling edge.
    always @(negedge clk) begin
        if (frame_err) fe_hi = fe_hi + 1;
        if (overrun) ov_hi = ov_hi + 1;
        if (empty_prev && !empty) last_fall_cyc = cyc;
        empty_prev = empty;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (got !== exp) begin
            n_miss = n_miss + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_bit(input logic v);
        rx_line = v;
        repeat (BAUD) @(posedge clk);
        #1;
    endtask

    // Start bit is driven 1 time unit after a posedge.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_bit);
        rx_line = 1'b1;
    endtask

    task automatic pop_one();
        @(negedge clk);
        rx_re = 1'b1;
        @(posedge clk);
        #1 rx_re = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int fe0, ov0, start_cyc, lat;

    initial begin
        // Reset
        #2 rst_n = 1'b0;
        #1;
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        idle_cycles(3);
        rst_n = 1'b1;
        idle_cycles(4);

        // 1: single byte 0xA5 with latency check
        fe0 = fe_hi; ov0 = ov_hi;
        @(posedge clk); #1;
        start_cyc = cyc;
        send_byte(8'hA5, 1'b1);
        @(negedge clk);
        lat = last_fall_cyc - start_cyc;
        check("t1_latency_150_158", 32'(lat >= 150 && lat <= 158), 32'd1);
        check("t1_empty", 32'(empty), 32'd0);
        check("t1_dout", 32'(dout), 32'hA5);
        check("t1_no_fe", 32'(fe_hi - fe0), 32'd0);
        check("t1_no_ov", 32'(ov_hi - ov0), 32'd0);
        pop_one();
        @(negedge clk);
        check("t1_empty_after_pop", 32'(empty), 32'd1);

        // 2: 5-cycle glitch is rejected
        fe0 = fe_hi; ov0 = ov_hi;
        rx_line = 1'b0;
        idle_cycles(5);
        rx_line = 1'b1;
        idle_cycles(3 * BAUD);
        check("t2_empty", 32'(empty), 32'd1);
        check("t2_no_flags", 32'((fe_hi - fe0) + (ov_hi - ov0)), 32'd0);

        // 3: framing error, then a good byte
        fe0 = fe_hi; ov0 = ov_hi;
        send_byte(8'h3C, 1'b0);
        idle_cycles(3 * BAUD);
        check("t3_fe_one_cycle", 32'(fe_hi - fe0), 32'd1);
        check("t3_no_ov", 32'(ov_hi - ov0), 32'd0);
        check("t3_empty", 32'(empty), 32'd1);
        send_byte(8'h55, 1'b1);
        @(negedge clk);
        check("t3_empty_after_55", 32'(empty), 32'd0);
        check("t3_dout_55", 32'(dout), 32'h55);
        check("t3_fe_still_one", 32'(fe_hi - fe0), 32'd1);
        pop_one();
        @(negedge clk);
        check("t3_empty_after_pop", 32'(empty), 32'd1);

        // 4: fill, overrun, drain with pointer wrap
        fe0 = fe_hi; ov0 = ov_hi;
        for (int i = 0; i < 32; i++) begin
            send_byte(8'(i), 1'b1);
            idle_cycles(2);
        end
        @(negedge clk);
        check("t4_full", 32'(full), 32'd1);
        check("t4_no_ov_yet", 32'(ov_hi - ov0), 32'd0);
        send_byte(8'hFF, 1'b1);
        idle_cycles(BAUD);
        check("t4_ov_once", 32'(ov_hi - ov0), 32'd1);
        check("t4_no_fe", 32'(fe_hi - fe0), 32'd0);
        check("t4_still_full", 32'(full), 32'd1);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            check($sformatf("t4_dout_%0d", i), 32'(dout), 32'(i));
            rx_re = 1'b1;
            @(posedge clk);
            #1 rx_re = 1'b0;
        end
        @(negedge clk);
        check("t4_empty_after_drain", 32'(empty), 32'd1);
        check("t4_not_full_after_drain", 32'(full), 32'd0);

        // 5: enable abort mid-byte, then a clean 0x81
        fe0 = fe_hi; ov0 = ov_hi;
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b0);
        rx_en = 1'b0;
        idle_cycles(2);
        rx_line = 1'b1;
        idle_cycles(6 * BAUD);
        check("t5_empty_after_abort", 32'(empty), 32'd1);
        check("t5_no_flags", 32'((fe_hi - fe0) + (ov_hi - ov0)), 32'd0);
        rx_en = 1'b1;
        idle_cycles(BAUD);
        send_byte(8'h81, 1'b1);
        @(negedge clk);
        check("t5_empty", 32'(empty), 32'd0);
        check("t5_dout_81", 32'(dout), 32'h81);
        pop_one();

        // 6: async reset mid-frame with 3 bytes queued
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        @(negedge clk);
        check("t6_queued_head", 32'(dout), 32'h11);
        fork
            send_byte(8'h99, 1'b1);
            begin
                repeat (70) @(posedge clk);
                @(negedge clk);
                #2 rst_n = 1'b0;
                #1;
                check("t6_rst_empty", 32'(empty), 32'd1);
                check("t6_rst_full", 32'(full), 32'd0);
            end
        join
        idle_cycles(BAUD);
        rst_n = 1'b1;
        idle_cycles(BAUD);
        check("t6_empty_after_release", 32'(empty), 32'd1);
        send_byte(8'h7E, 1'b1);
        @(negedge clk);
        check("t6_empty", 32'(empty), 32'd0);
        check("t6_dout_7e", 32'(dout), 32'h7E);
        pop_one();
        @(negedge clk);
        check("t6_empty_after_pop", 32'(empty), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Asynchronous serial receiver: 8N1 frames, LSB first, idle-high line, one start bit (0), one stop bit (1).
- Peer of the peripheral-bus UART transmitter. Shares its `baud_div_i` semantics: one bit period = `baud_div_i` clk_i cycles.
- Received bytes are buffered in a 32-entry FIFO, read by the UART register block through a first-word-fall-through pop interface.

Parameters:
- DEPTH, 32, FIFO entries; must be a power of two.
- SYNC_STAGES, 2, number of flops in the `rx_bit_i` synchronizer; minimum 2.

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  reset; asynchronous and active-low
- baud_div_i  in  16  clk_i cycles per bit; values < 4 are unsupported and force IDLE
- rx_en_i  in  1  receiver enable
- rx_re_i  in  1  FIFO pop strobe; ignored when empty_o = 1
- rx_bit_i  in  1  serial line, asynchronous to clk_i
- dout_o  out  8  FIFO head byte; valid when empty_o = 0
- full_o  out  1  FIFO full
- empty_o  out  1  FIFO empty
- frame_err_o  out  1  one-cycle pulse: stop bit sampled as 0, byte discarded
- overrun_o  out  1  one-cycle pulse: valid byte discarded because FIFO full

Behaviour:
- **Reset (async):** state = IDLE; all counters and pointers = 0; synchronizer flops = 1.
  - Output reset values: empty_o = 1, full_o = 0, frame_err_o = 0, overrun_o = 0.
  - dout_o is don't-care while empty. FIFO storage is not reset.
- **Synchronizer:** `rx_bit_i` passes through SYNC_STAGES flops; `rx_s` is the final stage. All decisions use `rx_s` only.
- **Baud counter:** 16-bit `baud_cnt`, cleared on every state entry. `half = baud_div_i >> 1` (floor).
- **FSM states:** IDLE, START, DATA, STOP.
  - IDLE: `rx_s == 0` and `rx_en_i` -> START.
  - START: when `baud_cnt == half-1`, sample `rx_s`.
    - 0 -> DATA with `bit_cnt = 0`.
    - 1 -> IDLE (glitch rejected, no flag).
  - DATA: when `baud_cnt == baud_div_i-1`, shift register `sh <= {rx_s, sh[7:1]}`.
    - `bit_cnt == 7` -> STOP; otherwise `bit_cnt + 1`.
  - STOP: when `baud_cnt == baud_div_i-1`, sample `rx_s`.
    - 1 and !full_o -> push `sh`.
    - 1 and full_o -> overrun_o pulse, byte dropped.
    - 0 -> frame_err_o pulse, byte dropped.
    - In all three cases -> IDLE.
    - A line held low after a framing error starts a new frame from IDLE: a break restarts reception repeatedly, as intended.
- **Sampling point:** samples land mid-bit, nominally `half + k*baud_div_i` cycles after the synchronized falling edge, for k = 1..9.
- **Enable:** `rx_en_i` low in any state -> IDLE next cycle; partial byte discarded, no flags. FIFO contents and the pop path are unaffected by `rx_en_i`.
- **FIFO pointers:** 6-bit rd/wr pointers (log2(DEPTH)+1 bits).
  - Pointer MSB differs and low bits equal -> full_o.
  - Pointers equal -> empty_o.
  - Pointers wrap naturally.
- **FIFO read:** `dout_o = mem[rd_ptr low bits]`, combinational (FWFT). `rx_re_i && !empty_o` advances rd_ptr.
- **FIFO write latency:** a pushed byte appears on dout_o and drops empty_o the cycle after the STOP sample.
- **Simultaneous push and pop:**
  - Both execute when not full.
  - When full, push is judged on pre-pop full_o, so the byte is dropped with overrun_o.
  - When empty, the pop is ignored and the push proceeds.
- **Flags:** frame_err_o and overrun_o are registered, high for exactly one cycle, and mutually exclusive.
- **baud_div_i:** changes mid-frame are undefined; software changes it only while `rx_en_i = 0`.

Decomposition:
- **tcore_param additions:**
  - `UART_FIFO_DEPTH = 32`.
  - `typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} uart_rx_state_t`.
- **Sub-module:** `uart_fifo` (parameterized DEPTH x 8, FWFT, push/pop/full/empty) is natural and reusable by the transmitter. The FSM, synchronizer and counters stay in uart_rx.

Test Plan:
1. **Single byte.** baud_div_i = 16, rx_en_i = 1, drive frame 0xA5 at 16 clk/bit -> empty_o falls about 154 cycles (±4) after the start edge; dout_o = 0xA5; no flags. Then pulse rx_re_i -> empty_o = 1.
2. **Glitch rejection.** 5-cycle low pulse on the idle line, baud_div_i = 16 -> FSM returns to IDLE, empty_o stays 1, no flags.
3. **Framing error.** Frame 0x3C with stop bit 0 -> frame_err_o high for exactly 1 cycle, FIFO unchanged. A following valid 0x55 is received correctly.
4. **Full and overrun.**
   - Send 32 bytes 0x00..0x1F without popping -> full_o = 1.
   - 33rd byte 0xFF -> overrun_o pulses once.
   - Pop 32 times -> dout_o sequence 0x00..0x1F, then empty_o = 1 (pointer wrap checked).
5. **Enable abort.** Deassert rx_en_i after 4 data bits of 0x81 -> no push, no flags. Re-enable and send 0x81 -> 0x81 received.
6. **Async reset mid-frame.** Assert rst_ni low during DATA with 3 bytes queued -> empty_o = 1 and full_o = 0 immediately (no clock edge needed). After release, a new 0x7E frame is received correctly.
